// File: rtl/sd_sector_server.sv
// Host-side responder for the u765 sd_lba/sd_rd/sd_wr/sd_ack sector handshake.
// Moves 512-byte sectors between a byte-wide backing memory and the client sector buffer.
module sd_sector_server #(
    parameter int                ADDR_W    = 25,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MEM_LAT   = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic [31:0]       img_size,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACK, S_RD_REQ, S_RD_WAIT, S_RD_PUT,
        S_WR_ADDR, S_WR_GET, S_WR_PUT, S_REL
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        idx_q, idx_d;
    logic [2:0]        lat_q, lat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              buf_wr_q, buf_wr_d;
    logic [7:0]        buf_dout_q, buf_dout_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic [31:0]       lba_q, lba_d;
    logic              rd_dir_q, rd_dir_d;
    logic              in_rng_q, in_rng_d;

    logic [40:0]       req_last;
    logic              req_in_range;
    logic [ADDR_W-1:0] byte_addr;

    // Last byte of the requested sector must lie inside the image; 41 bits avoid lba*512 overflow.
    assign req_last     = {sd_lba, 9'h1FF};
    assign req_in_range = (img_size != 32'd0) && (req_last < {9'd0, img_size});
    assign byte_addr    = BASE_ADDR + ADDR_W'({lba_q, 9'd0}) + ADDR_W'(idx_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        err_d      = 1'b0;
        buf_wr_d   = 1'b0;
        buf_dout_d = buf_dout_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        lba_d      = lba_q;
        rd_dir_d   = rd_dir_q;
        in_rng_d   = in_rng_q;

        case (state_q)
            S_IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_d    = sd_lba;
                    rd_dir_d = sd_rd;
                    in_rng_d = req_in_range;
                    err_d    = !req_in_range;
                    idx_d    = 9'd0;
                    state_d  = S_ACK;
                end
            end
            S_ACK: state_d = rd_dir_q ? S_RD_REQ : S_WR_ADDR;
            S_RD_REQ: begin
                if (ce) begin
                    mem_rd_d = in_rng_q;
                    if (in_rng_q) mem_addr_d = byte_addr;
                    lat_d   = 3'd0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // lat_q counts cycles since the mem_rd cycle; data is valid when it reaches MEM_LAT.
                if (lat_q == 3'(MEM_LAT)) begin
                    buf_dout_d = in_rng_q ? mem_din : 8'hFF;
                    buf_wr_d   = 1'b1;
                    state_d    = S_RD_PUT;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_WR_ADDR: begin
                if (ce) state_d = S_WR_GET;
            end
            S_WR_GET: begin
                mem_wr_d = in_rng_q;
                if (in_rng_q) begin
                    mem_dout_d = sd_buff_din;
                    mem_addr_d = byte_addr;
                end
                state_d = S_WR_PUT;
            end
            S_RD_PUT, S_WR_PUT: begin
                idx_d = idx_q + 9'd1;
                if (idx_q == 9'd511) state_d = S_REL;
                else                 state_d = rd_dir_q ? S_RD_REQ : S_WR_ADDR;
            end
            S_REL: begin
                if (!sd_rd && !sd_wr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ack_d = (state_d != S_IDLE) && (state_d != S_REL);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 9'd0;
            lat_q      <= 3'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            buf_wr_q   <= 1'b0;
            buf_dout_q <= 8'd0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            buf_wr_q   <= buf_wr_d;
            buf_dout_q <= buf_dout_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        lba_q    <= lba_d;
        rd_dir_q <= rd_dir_d;
        in_rng_q <= in_rng_d;
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = idx_q;
    assign sd_buff_dout = buf_dout_q;
    assign sd_buff_wr   = buf_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_dout     = mem_dout_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sd_sector_server.sv
// Bench for sd_sector_server: byte memory and client buffer models plus a sector-level
// reference model that predicts every strobe, address and data byte of each transfer.
module tb_sd_sector_server;

    localparam int ADDR_W  = 25;
    localparam int MEM_LAT = 2;
    localparam int MEM_SZ  = 8192;

    logic              clk = 1'b0;
    logic              reset, ce;
    logic [31:0]       img_size, sd_lba;
    logic              sd_rd, sd_wr;
    logic              sd_ack, sd_buff_wr, mem_rd, mem_wr, err;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout, sd_buff_din, mem_dout, mem_din;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    sd_sector_server #(.ADDR_W(ADDR_W), .BASE_ADDR('0), .MEM_LAT(MEM_LAT)) dut (
        .clk_sys(clk), .reset(reset), .ce(ce), .img_size(img_size),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din(sd_buff_din), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .err(err)
    );

    // Environment: backing memory with MEM_LAT read latency, client buffer with 1-cycle read.
    logic [7:0] mem     [0:MEM_SZ-1];
    logic [7:0] ref_mem [0:MEM_SZ-1];
    logic [7:0] cbuf    [0:511];
    logic [7:0] rdpipe  [0:MEM_LAT-1];
    logic       init_go = 1'b0;
    int         init_mode = 0, init_seed = 0;

    function automatic logic [7:0] init_val(int i, int mode, int seed);
        if (mode == 0) return 8'(i) ^ 8'h5A;
        return 8'((i * 173 + seed) ^ (i >>> 5) ^ (seed >>> 11));
    endfunction

    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < MEM_SZ; i++) mem[i] <= init_val(i, init_mode, init_seed);
        end else if (mem_wr) begin
            mem[mem_addr[12:0]] <= mem_dout;
        end
        rdpipe[0] <= mem_rd ? mem[mem_addr[12:0]] : 8'hEE;
        for (int i = 1; i < MEM_LAT; i++) rdpipe[i] <= rdpipe[i-1];
        sd_buff_din <= cbuf[sd_buff_addr];
    end
    assign mem_din = rdpipe[MEM_LAT-1];

    // Monitor: log every strobe away from the active edge.
    logic [8:0]        bw_addr[$];
    logic [7:0]        bw_data[$];
    logic [ADDR_W-1:0] mr_addr[$];
    logic [ADDR_W-1:0] mw_addr[$];
    logic [7:0]        mw_data[$];
    int                err_n = 0, ack_rise_n = 0, ack_hi_n = 0;
    logic              ack_prev = 1'b0;

    always @(negedge clk) begin
        if (sd_buff_wr) begin bw_addr.push_back(sd_buff_addr); bw_data.push_back(sd_buff_dout); end
        if (mem_rd) mr_addr.push_back(mem_addr);
        if (mem_wr) begin mw_addr.push_back(mem_addr); mw_data.push_back(mem_dout); end
        if (err) err_n <= err_n + 1;
        if (sd_ack) ack_hi_n <= ack_hi_n + 1;
        if (sd_ack && !ack_prev) ack_rise_n <= ack_rise_n + 1;
        ack_prev <= sd_ack;
    end

    // ce pacing: 0 = random, N >= 1 = one ce every N cycles.
    int ce_mode = 1;
    initial begin
        int n;
        n = 0;
        ce = 1'b0;
        forever begin
            @(negedge clk);
            if (ce_mode == 0) ce = 1'($urandom_range(0, 1));
            else              ce = ((n % ce_mode) == 0);
            n++;
        end
    end

    int n_total = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit ref_in_range(logic [31:0] img, logic [31:0] lba);
        longint unsigned last;
        last = {32'd0, lba} * 512 + 511;
        return (img != 32'd0) && (last < {32'd0, img});
    endfunction

    task automatic set_mem(input int mode, input int seed);
        @(negedge clk);
        init_mode = mode;
        init_seed = seed;
        init_go   = 1'b1;
        @(negedge clk);
        init_go = 1'b0;
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_val(i, mode, seed);
    endtask

    task automatic run_xfer(input string name, input bit rd, input bit wr,
                            input logic [31:0] lba, input int hold);
        int bw0, mr0, mw0, err0, rise0, hi0, nbw, nmr, nmw, mism;
        bit inr, timeout;
        longint unsigned base_l;
        logic [7:0] exp_b;
        inr    = ref_in_range(img_size, lba);
        base_l = {32'd0, lba} * 512;
        @(negedge clk);
        bw0 = bw_addr.size(); mr0 = mr_addr.size(); mw0 = mw_addr.size();
        err0 = err_n; rise0 = ack_rise_n;
        sd_lba = lba; sd_rd = rd; sd_wr = wr;
        @(negedge clk);
        sd_lba = $urandom;
        timeout = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if (ack_rise_n > rise0 && !sd_ack) begin timeout = 1'b0; break; end
            @(negedge clk);
        end
        check({name, "_done"}, 64'(timeout), 64'd0);
        @(negedge clk);
        hi0 = ack_hi_n;
        repeat (hold) @(negedge clk);
        check({name, "_ack_low_held"}, 64'(ack_hi_n - hi0), 64'd0);
        sd_rd = 1'b0; sd_wr = 1'b0;
        repeat (4) @(negedge clk);

        nbw = bw_addr.size() - bw0;
        nmr = mr_addr.size() - mr0;
        nmw = mw_addr.size() - mw0;
        check({name, "_ack_rises"}, 64'(ack_rise_n - rise0), 64'd1);
        check({name, "_err"}, 64'(err_n - err0), inr ? 64'd0 : 64'd1);
        if (rd) begin
            check({name, "_nbuffwr"}, 64'(nbw), 64'd512);
            mism = 0;
            for (int k = 0; k < nbw && k < 512; k++) begin
                exp_b = inr ? ref_mem[int'(base_l) + k] : 8'hFF;
                if (bw_addr[bw0+k] !== 9'(k) || bw_data[bw0+k] !== exp_b) mism++;
            end
            check({name, "_rd_bytes_bad"}, 64'(mism), 64'd0);
            check({name, "_nmemrd"}, 64'(nmr), inr ? 64'd512 : 64'd0);
            mism = 0;
            for (int k = 0; k < nmr && k < 512; k++)
                if (mr_addr[mr0+k] !== ADDR_W'(base_l + longint'(k))) mism++;
            check({name, "_rd_addr_bad"}, 64'(mism), 64'd0);
            check({name, "_nmemwr"}, 64'(nmw), 64'd0);
        end else begin
            if (inr) for (int k = 0; k < 512; k++) ref_mem[int'(base_l) + k] = cbuf[k];
            check({name, "_nmemwr"}, 64'(nmw), inr ? 64'd512 : 64'd0);
            mism = 0;
            for (int k = 0; k < nmw && k < 512; k++)
                if (mw_addr[mw0+k] !== ADDR_W'(base_l + longint'(k)) || mw_data[mw0+k] !== cbuf[k]) mism++;
            check({name, "_wr_bytes_bad"}, 64'(mism), 64'd0);
            check({name, "_nbuffwr"}, 64'(nbw), 64'd0);
            check({name, "_nmemrd"}, 64'(nmr), 64'd0);
        end
        mism = 0;
        for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) mism++;
        check({name, "_mem_image_bad"}, 64'(mism), 64'd0);
    endtask

    initial begin
        int bw0, bw1, mr1;
        bit reached;
        int imgs[4];
        imgs[0] = 4096; imgs[1] = 2560; imgs[2] = 1024; imgs[3] = 0;

        reset = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = '0; img_size = '0;
        for (int k = 0; k < 512; k++) cbuf[k] = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_outs", 64'({sd_ack, sd_buff_wr, mem_rd, mem_wr, err, sd_buff_addr,
                                 sd_buff_dout, mem_dout, mem_addr}), 64'd0);
        reset = 1'b0;

        // Sector read of an in-range sector with ce every cycle.
        img_size = 32'd4096;
        set_mem(0, 0);
        ce_mode = 1;
        run_xfer("t1_rd", 1'b1, 1'b0, 32'd3, 0);

        // Sector write with random ce pacing.
        for (int k = 0; k < 512; k++) cbuf[k] = ~8'(k);
        ce_mode = 0;
        run_xfer("t2_wr", 1'b0, 1'b1, 32'd1, 0);

        // Out-of-range requests and image-size boundaries.
        ce_mode = 1;
        img_size = 32'd1024;
        run_xfer("t3_rd_oor", 1'b1, 1'b0, 32'd2, 0);
        run_xfer("t3_wr_oor", 1'b0, 1'b1, 32'd2, 0);
        run_xfer("t3_rd_last", 1'b1, 1'b0, 32'd1, 0);
        img_size = 32'd1023;
        run_xfer("t3_wr_short", 1'b0, 1'b1, 32'd1, 0);
        img_size = 32'd0;
        run_xfer("t3_noimg", 1'b1, 1'b0, 32'd0, 0);
        img_size = 32'd4096;
        run_xfer("t3_wide_lba", 1'b1, 1'b0, 32'h0080_0001, 0);

        // Both requests in the same cycle: read wins.
        run_xfer("t4_both", 1'b1, 1'b1, 32'd0, 0);

        // Reset after 100 bytes of a read.
        @(negedge clk);
        bw0 = bw_addr.size();
        sd_lba = 32'd3; sd_rd = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bw_addr.size() - bw0 >= 100) begin reached = 1'b1; break; end
        end
        check("t5_reach_byte100", 64'(reached), 64'd1);
        reset = 1'b1; sd_rd = 1'b0;
        @(negedge clk);
        check("t5_outs_after_reset", 64'({sd_ack, sd_buff_wr, mem_rd, mem_wr, err, sd_buff_addr}), 64'd0);
        reset = 1'b0;
        bw1 = bw_addr.size(); mr1 = mr_addr.size();
        repeat (20) @(negedge clk);
        check("t5_quiet_buffwr", 64'(bw_addr.size() - bw1), 64'd0);
        check("t5_quiet_memrd", 64'(mr_addr.size() - mr1), 64'd0);
        run_xfer("t5_fresh", 1'b1, 1'b0, 32'd3, 0);

        // Request held long after completion, slow ce.
        ce_mode = 4;
        run_xfer("t6_hold", 1'b1, 1'b0, 32'd5, 1000);

        // Randomized transfers on random memory content.
        set_mem(1, int'($urandom));
        for (int t = 0; t < 6; t++) begin
            bit r, w;
            img_size = imgs[$urandom_range(0, 3)];
            ce_mode = int'($urandom_range(0, 3));
            for (int k = 0; k < 512; k++) cbuf[k] = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       begin r = 1'b1; w = 1'b0; end
                1:       begin r = 1'b0; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            run_xfer("rnd", r, w, 32'($urandom_range(0, 9)), int'($urandom_range(0, 20)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
